// File: rtl/pipeline_hazard_ctrl_if.sv
// Datapath <-> hazard controller bundle: pipeline-register flags in, control bundle out.
interface pipeline_hazard_ctrl_if #(
    parameter int unsigned CNT_WIDTH = 32
);
    logic                 icache_resp;
    logic                 dcache_resp;
    logic                 exmem_dcache_read;
    logic                 exmem_dcache_write;
    logic [4:0]           ifid_rs1;
    logic [4:0]           ifid_rs2;
    logic                 ifid_rs1_used;
    logic                 ifid_rs2_used;
    logic [4:0]           idex_rs1;
    logic [4:0]           idex_rs2;
    logic [4:0]           idex_rd;
    logic                 idex_dcache_read;
    logic [4:0]           exmem_rd;
    logic                 exmem_load_regfile;
    logic [4:0]           memwb_rd;
    logic                 memwb_load_regfile;
    logic                 br_taken;

    logic                 icache_read;
    logic                 dcache_read_en;
    logic                 dcache_write_en;
    logic                 pc_load;
    logic [1:0]           rs1mux_sel;
    logic [1:0]           rs2mux_sel;
    logic                 pipe_load_ifid;
    logic                 pipe_load_idex;
    logic                 pipe_load_exmem;
    logic                 pipe_load_memwb;
    logic                 pipe_rst_ifid;
    logic                 pipe_rst_idex;
    logic                 pipe_rst_exmem;
    logic                 pipe_rst_memwb;
    logic [CNT_WIDTH-1:0] stall_cycles;
    logic [CNT_WIDTH-1:0] flush_count;

    // Datapath side: supplies stage flags, consumes the control bundle.
    modport master (
        output icache_resp, dcache_resp, exmem_dcache_read, exmem_dcache_write,
               ifid_rs1, ifid_rs2, ifid_rs1_used, ifid_rs2_used,
               idex_rs1, idex_rs2, idex_rd, idex_dcache_read,
               exmem_rd, exmem_load_regfile, memwb_rd, memwb_load_regfile, br_taken,
        input  icache_read, dcache_read_en, dcache_write_en, pc_load,
               rs1mux_sel, rs2mux_sel,
               pipe_load_ifid, pipe_load_idex, pipe_load_exmem, pipe_load_memwb,
               pipe_rst_ifid, pipe_rst_idex, pipe_rst_exmem, pipe_rst_memwb,
               stall_cycles, flush_count
    );

    // Controller side.
    modport slave (
        input  icache_resp, dcache_resp, exmem_dcache_read, exmem_dcache_write,
               ifid_rs1, ifid_rs2, ifid_rs1_used, ifid_rs2_used,
               idex_rs1, idex_rs2, idex_rd, idex_dcache_read,
               exmem_rd, exmem_load_regfile, memwb_rd, memwb_load_regfile, br_taken,
        output icache_read, dcache_read_en, dcache_write_en, pc_load,
               rs1mux_sel, rs2mux_sel,
               pipe_load_ifid, pipe_load_idex, pipe_load_exmem, pipe_load_memwb,
               pipe_rst_ifid, pipe_rst_idex, pipe_rst_exmem, pipe_rst_memwb,
               stall_cycles, flush_count
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage RV32I pipeline: forwarding,
// cache-miss freeze, load-use bubble, branch flush and event counters.
module pipeline_hazard_ctrl #(
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    pipeline_hazard_ctrl_if.slave  bus
);

    logic                 icache_done_q, icache_done_d;
    logic                 dcache_done_q, dcache_done_d;
    logic [CNT_WIDTH-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_WIDTH-1:0] flush_count_q, flush_count_d;

    logic i_ok;
    logic d_ok;
    logic stall;
    logic load_use;

    // EX/MEM result wins over MEM/WB; x0 is never forwarded.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        if (bus.exmem_load_regfile && (bus.exmem_rd != 5'd0) && (bus.exmem_rd == rs))
            return 2'b01;
        else if (bus.memwb_load_regfile && (bus.memwb_rd != 5'd0) && (bus.memwb_rd == rs))
            return 2'b10;
        else
            return 2'b00;
    endfunction

    // Freeze and load-use condition terms.
    always_comb begin
        i_ok     = bus.icache_resp || icache_done_q;
        d_ok     = !(bus.exmem_dcache_read || bus.exmem_dcache_write)
                   || bus.dcache_resp || dcache_done_q;
        stall    = !(i_ok && d_ok);
        load_use = bus.idex_dcache_read && (bus.idex_rd != 5'd0) &&
                   ((bus.ifid_rs1_used && (bus.ifid_rs1 == bus.idex_rd)) ||
                    (bus.ifid_rs2_used && (bus.ifid_rs2 == bus.idex_rd)));
    end

    // Control bundle: reset > stall > flush > bubble > run.
    always_comb begin
        bus.icache_read     = !icache_done_q;
        bus.dcache_read_en  = bus.exmem_dcache_read  && !dcache_done_q;
        bus.dcache_write_en = bus.exmem_dcache_write && !dcache_done_q;
        bus.rs1mux_sel      = fwd_sel(bus.idex_rs1);
        bus.rs2mux_sel      = fwd_sel(bus.idex_rs2);
        bus.pc_load         = 1'b1;
        bus.pipe_load_ifid  = 1'b1;
        bus.pipe_load_idex  = 1'b1;
        bus.pipe_load_exmem = 1'b1;
        bus.pipe_load_memwb = 1'b1;
        bus.pipe_rst_ifid   = 1'b0;
        bus.pipe_rst_idex   = 1'b0;
        bus.pipe_rst_exmem  = 1'b0;
        bus.pipe_rst_memwb  = 1'b0;

        if (rst) begin
            bus.icache_read     = 1'b0;
            bus.dcache_read_en  = 1'b0;
            bus.dcache_write_en = 1'b0;
            bus.rs1mux_sel      = 2'b00;
            bus.rs2mux_sel      = 2'b00;
            bus.pc_load         = 1'b0;
            bus.pipe_load_ifid  = 1'b0;
            bus.pipe_load_idex  = 1'b0;
            bus.pipe_load_exmem = 1'b0;
            bus.pipe_load_memwb = 1'b0;
            bus.pipe_rst_ifid   = 1'b1;
            bus.pipe_rst_idex   = 1'b1;
            bus.pipe_rst_exmem  = 1'b1;
            bus.pipe_rst_memwb  = 1'b1;
        end else if (stall) begin
            bus.pc_load         = 1'b0;
            bus.pipe_load_ifid  = 1'b0;
            bus.pipe_load_idex  = 1'b0;
            bus.pipe_load_exmem = 1'b0;
            bus.pipe_load_memwb = 1'b0;
        end else if (bus.br_taken) begin
            bus.pipe_rst_ifid   = 1'b1;
            bus.pipe_rst_idex   = 1'b1;
        end else if (load_use) begin
            bus.pc_load         = 1'b0;
            bus.pipe_load_ifid  = 1'b0;
            bus.pipe_rst_idex   = 1'b1;
        end
    end

    // Response latches hold early pulses across a freeze; counters saturate.
    always_comb begin
        icache_done_d  = icache_done_q;
        dcache_done_d  = dcache_done_q;
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;

        if (stall) begin
            if (bus.icache_resp) icache_done_d = 1'b1;
            if (bus.dcache_resp) dcache_done_d = 1'b1;
            if (stall_cycles_q != '1)
                stall_cycles_d = stall_cycles_q + CNT_WIDTH'(1);
        end else begin
            icache_done_d = 1'b0;
            dcache_done_d = 1'b0;
            if (bus.br_taken && (flush_count_q != '1))
                flush_count_d = flush_count_q + CNT_WIDTH'(1);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            icache_done_q  <= 1'b0;
            dcache_done_q  <= 1'b0;
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            icache_done_q  <= icache_done_d;
            dcache_done_q  <= dcache_done_d;
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign bus.stall_cycles = stall_cycles_q;
    assign bus.flush_count  = flush_count_q;

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Hazard and sequencing controller for the 5-stage RV32I pipeline.
- Generates the `control` bundle: forwarding selects, per-stage pipe load enables and per-stage synchronous resets.
- Handles four things: cache-miss freezes (with latched response pulses), load-use bubbles, taken-branch flushes, and stall/flush event counters.
- Sits beside the datapath and consumes register indices and stage flags from the IF/ID, ID/EX, EX/MEM and MEM/WB registers.

Parameters:
- CNT_WIDTH, 32, width of the stall_cycles and flush_count counters (saturating).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- icache_resp  in  1  one-cycle pulse: fetch data valid
- dcache_resp  in  1  one-cycle pulse: data access complete
- exmem_dcache_read  in  1  EX/MEM instruction reads memory
- exmem_dcache_write  in  1  EX/MEM instruction writes memory
- ifid_rs1, ifid_rs2  in  5 each  source registers of the IF/ID instruction
- ifid_rs1_used, ifid_rs2_used  in  1 each  IF/ID instruction reads rs1/rs2
- idex_rs1, idex_rs2  in  5 each  source registers in ID/EX
- idex_rd  in  5  destination in ID/EX
- idex_dcache_read  in  1  ID/EX instruction is a load
- exmem_rd  in  5  destination in EX/MEM
- exmem_load_regfile  in  1  EX/MEM writes the register file
- memwb_rd  in  5  destination in MEM/WB
- memwb_load_regfile  in  1  MEM/WB writes the register file
- br_taken  in  1  EX-stage branch/jump redirect
- icache_read  out  1  fetch request to I-cache
- dcache_read_en, dcache_write_en  out  1 each  gated D-cache request
- pc_load  out  1  PC register load enable
- rs1mux_sel, rs2mux_sel  out  2 each  forwarding select for the EX operands
- pipe_load_ifid, pipe_load_idex, pipe_load_exmem, pipe_load_memwb  out  1 each  stage load enables
- pipe_rst_ifid, pipe_rst_idex, pipe_rst_exmem, pipe_rst_memwb  out  1 each  stage synchronous clears
- stall_cycles  out  CNT_WIDTH  cycles with stall=1
- flush_count  out  CNT_WIDTH  number of flushes issued

Behaviour:
- Clock and reset:
  - Single clock, clk; rst is synchronous and active-high.
  - While rst=1: all pipe_rst_*=1; all pipe_load_*=0; pc_load=0; icache_read=0; dcache_*_en=0; mux selects=0.
  - Flags icache_done and dcache_done clear to 0; both counters clear to 0.
- Forwarding (combinational, applied independently to rs1 and rs2):
  - 2'b01 when exmem_load_regfile && exmem_rd!=0 && exmem_rd==idex_rsN.
  - Otherwise 2'b10 when memwb_load_regfile && memwb_rd!=0 && memwb_rd==idex_rsN.
  - Otherwise 2'b00. 2'b11 is never driven.
  - EX/MEM has priority over MEM/WB.
- Response latches:
  - icache_done sets on icache_resp when stall=1.
  - dcache_done sets on dcache_resp when stall=1.
  - Both clear on any cycle with stall=0.
  - icache_read = !icache_done.
  - dcache_read_en = exmem_dcache_read && !dcache_done; dcache_write_en likewise with exmem_dcache_write.
- Condition terms:
  - i_ok = icache_resp || icache_done.
  - d_ok = !(exmem_dcache_read || exmem_dcache_write) || dcache_resp || dcache_done.
  - stall = !(i_ok && d_ok).
  - load_use = idex_dcache_read && idex_rd!=0 && ((ifid_rs1_used && ifid_rs1==idex_rd) || (ifid_rs2_used && ifid_rs2==idex_rd)).
- Action priority (highest first), outputs combinational:
  - STALL (stall=1): all loads=0, pc_load=0, all pipe_rst=0.
  - FLUSH (br_taken): all loads=1, pc_load=1, pipe_rst_ifid=1, pipe_rst_idex=1. A flush overrides a simultaneous load-use.
  - BUBBLE (load_use): pc_load=0, load_ifid=0, load_idex=1 with pipe_rst_idex=1, load_exmem=1, load_memwb=1.
  - RUN: all loads=1, pc_load=1, all pipe_rst=0.
- pipe_rst_exmem and pipe_rst_memwb are asserted only during rst.
- Counters:
  - stall_cycles increments each non-reset cycle with stall=1.
  - flush_count increments once per non-stalled cycle with br_taken.
  - Both saturate at all-ones.
- Mid-operation reset: a rst during a stall discards the latched flags; the first cycle after reset is evaluated fresh.

Test Plan:
- ALU chain: exmem_rd=5, exmem_load_regfile=1, memwb_rd=5, idex_rs1=5 -> rs1mux_sel=2'b01. Same with exmem_rd=0 -> 2'b10.
- Load-use: idex_dcache_read=1, idex_rd=3, ifid_rs2=3, ifid_rs2_used=1 -> one cycle with pc_load=0, load_ifid=0, pipe_rst_idex=1. The next cycle is RUN once the load has advanced.
- Split responses: D-access pending; icache_resp at cycle 2, dcache_resp at cycle 6.
  - icache_read drops at cycle 3.
  - Stall holds through cycle 5; all loads=1 at cycle 6.
  - stall_cycles=5.
- Flush vs bubble: br_taken=1 with load_use=1 -> pipe_rst_ifid=1, pipe_rst_idex=1, pc_load=1, flush_count +1.
- Flush during stall: br_taken=1 with dcache pending for 3 cycles -> no rst/loads for 3 cycles, then a single flush and flush_count +1 only once.
- Reset mid-stall: rst at cycle 2 of a miss -> all pipe_rst=1 and flags cleared; the next cycle re-requests with icache_read=1.
